// File: rtl/press_counter_bank.sv
// press_counter_bank: NUM_CH independent push-button counters, each either
// hex or BCD, with a sticky wrap/saturate flag and a display selector that
// can be stepped by next_ch or auto-scrolled every SCROLL_CYC cycles.
// Optional feature macro: PRESS_COUNTER_BANK_SATURATE_EN -- when defined the
// counters hold at their limits instead of wrapping around.
module press_counter_bank #(
  parameter int                NUM_CH     = 4,
  parameter int                NUM_DIGITS = 4,
  parameter logic [NUM_CH-1:0] DEC_MASK   = 4'b0101,
  parameter int                SCROLL_CYC = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CH-1:0]                    inc,
  input  logic [NUM_CH-1:0]                    dec,
  input  logic [NUM_CH-1:0]                    clr,
  input  logic                                 next_ch,
  output logic [NUM_CH*NUM_DIGITS*4-1:0]       count,
  output logic [NUM_CH-1:0]                    wrap_flag,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] disp_ch,
  output logic [NUM_DIGITS*4-1:0]              encoded,
  output logic [NUM_DIGITS-1:0]                digit_point
);

  localparam int W    = NUM_DIGITS * 4;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DW   = (SCROLL_CYC > 1) ? $clog2(SCROLL_CYC) : 1;
  localparam bit SCROLL_EN = (SCROLL_CYC > 0);

  localparam logic [W-1:0]    ZERO_VAL   = {W{1'b0}};
  localparam logic [W-1:0]    ONE_VAL    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]    HEX_MAX    = {W{1'b1}};
  localparam logic [W-1:0]    BCD_MAX    = {NUM_DIGITS{4'h9}};
  localparam logic [CH_W-1:0] LAST_CH    = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0] ONE_CH     = {{(CH_W-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0]   DWELL_LAST = (SCROLL_CYC > 1) ? DW'(SCROLL_CYC - 1) : {DW{1'b0}};
  localparam logic [DW-1:0]   ONE_DW     = {{(DW-1){1'b0}}, 1'b1};

  // BCD ripple step: digits roll 9->0 going up, 0->9 going down, and the
  // carry/borrow continues only while a digit rolls over.
  function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic up);
    logic [W-1:0] r;
    logic         ripple;
    r      = v;
    ripple = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (ripple) begin
        if (up) begin
          if (v[d*4 +: 4] == 4'd9) begin
            r[d*4 +: 4] = 4'd0;
          end else begin
            r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
            ripple      = 1'b0;
          end
        end else begin
          if (v[d*4 +: 4] == 4'd0) begin
            r[d*4 +: 4] = 4'd9;
          end else begin
            r[d*4 +: 4] = v[d*4 +: 4] - 4'd1;
            ripple      = 1'b0;
          end
        end
      end else begin
        r[d*4 +: 4] = v[d*4 +: 4];
      end
    end
    return r;
  endfunction

  // One wrapping step up or down in the channel's number system.
  function automatic logic [W-1:0] step_val(input logic [W-1:0] v, input logic is_dec,
                                            input logic up);
    if (is_dec) begin
      return bcd_step(v, up);
    end else if (up) begin
      return v + ONE_VAL;
    end else begin
      return v - ONE_VAL;
    end
  endfunction

  logic [W-1:0]      count_r      [NUM_CH];
  logic [W-1:0]      next_count_s [NUM_CH];
  logic [NUM_CH-1:0] wrap_flag_r;
  logic [NUM_CH-1:0] next_wrap_s;
  logic [CH_W-1:0]   disp_ch_r;
  logic [CH_W-1:0]   next_disp_s;
  logic [DW-1:0]     dwell_r;
  logic [DW-1:0]     next_dwell_s;
  logic              advance_s;
  logic [W-1:0]          encoded_r;
  logic [NUM_DIGITS-1:0] digit_point_r;
  logic [NUM_DIGITS-1:0] next_dp_s;

  // Per-channel next count and sticky flag: clr wins, inc+dec cancel.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      next_count_s[i] = count_r[i];
      next_wrap_s[i]  = wrap_flag_r[i];
      if (clr[i]) begin
        next_count_s[i] = ZERO_VAL;
        next_wrap_s[i]  = 1'b0;
      end else if (inc[i] ^ dec[i]) begin
        if (inc[i] ? (count_r[i] == (DEC_MASK[i] ? BCD_MAX : HEX_MAX))
                   : (count_r[i] == ZERO_VAL)) begin
          next_wrap_s[i] = 1'b1;
`ifdef PRESS_COUNTER_BANK_SATURATE_EN
          next_count_s[i] = count_r[i];
`else
          next_count_s[i] = step_val(count_r[i], DEC_MASK[i], inc[i]);
`endif
        end else begin
          next_count_s[i] = step_val(count_r[i], DEC_MASK[i], inc[i]);
        end
      end else begin
        next_count_s[i] = count_r[i];
      end
    end
  end

  // Display selector: manual or dwell-timed advance; dwell restarts on any advance.
  always_comb begin
    advance_s    = next_ch | (SCROLL_EN & (dwell_r == DWELL_LAST));
    next_disp_s  = disp_ch_r;
    next_dwell_s = dwell_r;
    if (advance_s) begin
      next_disp_s  = (disp_ch_r == LAST_CH) ? {CH_W{1'b0}} : (disp_ch_r + ONE_CH);
      next_dwell_s = {DW{1'b0}};
    end else if (SCROLL_EN) begin
      next_dwell_s = dwell_r + ONE_DW;
    end else begin
      next_dwell_s = {DW{1'b0}};
    end
  end

  // Decimal points: wrap flag on digit 0, BCD marker on the top digit.
  always_comb begin
    next_dp_s               = {NUM_DIGITS{1'b0}};
    next_dp_s[0]            = wrap_flag_r[disp_ch_r];
    next_dp_s[NUM_DIGITS-1] = next_dp_s[NUM_DIGITS-1] | DEC_MASK[disp_ch_r];
  end

  // Counter and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        count_r[i] <= ZERO_VAL;
      end
      wrap_flag_r <= {NUM_CH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        count_r[i] <= next_count_s[i];
      end
      wrap_flag_r <= next_wrap_s;
    end
  end

  // Display selector and dwell timer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_ch_r <= {CH_W{1'b0}};
      dwell_r   <= {DW{1'b0}};
    end else begin
      disp_ch_r <= next_disp_s;
      dwell_r   <= next_dwell_s;
    end
  end

  // Display output registers, one cycle behind the counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      encoded_r     <= ZERO_VAL;
      digit_point_r <= {NUM_DIGITS{1'b0}};
    end else begin
      encoded_r     <= count_r[disp_ch_r];
      digit_point_r <= next_dp_s;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_count_out
    assign count[g*W +: W] = count_r[g];
  end

  assign wrap_flag   = wrap_flag_r;
  assign disp_ch     = disp_ch_r;
  assign encoded     = encoded_r;
  assign digit_point = digit_point_r;

endmodule

// File: tb/tb_press_counter_bank.sv
// Testbench for press_counter_bank: 4 channels of 2 digits, ch2 BCD, others
// hex, auto-scroll every 8 cycles. Directed boundary steps plus randomized
// pulses, checked against a numeric reference model.
module tb_press_counter_bank;

  localparam int         NCH   = 4;
  localparam int         SCR   = 8;
  localparam logic [3:0] DMASK = 4'b0100;
`ifdef PRESS_COUNTER_BANK_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam logic [7:0] HEX_OVER_EXP  = SAT ? 8'hFF : 8'h00;
  localparam logic [7:0] DEC_UNDER_EXP = SAT ? 8'h00 : 8'h99;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  inc, dec, clr;
  logic        next_ch;
  logic [31:0] count;
  logic [3:0]  wrap_flag;
  logic [1:0]  disp_ch;
  logic [7:0]  encoded;
  logic [1:0]  digit_point;

  int tests    = 0;
  int failures = 0;

  // reference model: plain integer counts per channel
  int         m_val  [NCH];
  bit         m_wrap [NCH];
  int         m_disp;
  int         m_since;
  logic [7:0] m_enc;
  logic [1:0] m_dp;

  press_counter_bank #(
    .NUM_CH(4), .NUM_DIGITS(2), .DEC_MASK(DMASK), .SCROLL_CYC(SCR)
  ) dut (
    .clk(clk), .reset(reset), .inc(inc), .dec(dec), .clr(clr),
    .next_ch(next_ch), .count(count), .wrap_flag(wrap_flag),
    .disp_ch(disp_ch), .encoded(encoded), .digit_point(digit_point)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] enc_val(input int ch, input int v);
    logic [7:0] r;
    if (DMASK[ch]) begin
      r[7:4] = 4'((v / 10) % 10);
      r[3:0] = 4'(v % 10);
    end else begin
      r = 8'(v);
    end
    return r;
  endfunction

  function automatic int max_of(input int ch);
    return DMASK[ch] ? 99 : 255;
  endfunction

  function automatic logic [31:0] exp_count();
    logic [31:0] r;
    for (int ch = 0; ch < NCH; ch++) r[ch*8 +: 8] = enc_val(ch, m_val[ch]);
    return r;
  endfunction

  function automatic logic [3:0] exp_wrap();
    logic [3:0] r;
    for (int ch = 0; ch < NCH; ch++) r[ch] = m_wrap[ch];
    return r;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      m_val[ch]  = 0;
      m_wrap[ch] = 1'b0;
    end
    m_disp  = 0;
    m_since = 0;
    m_enc   = 8'h00;
    m_dp    = 2'b00;
  endtask

  task automatic model_edge(input logic [3:0] i, input logic [3:0] d,
                            input logic [3:0] c, input logic n);
    m_enc = enc_val(m_disp, m_val[m_disp]);
    m_dp  = {DMASK[m_disp], m_wrap[m_disp]};
    for (int ch = 0; ch < NCH; ch++) begin
      if (c[ch]) begin
        m_val[ch]  = 0;
        m_wrap[ch] = 1'b0;
      end else if (i[ch] && !d[ch]) begin
        if (m_val[ch] == max_of(ch)) begin
          m_wrap[ch] = 1'b1;
          m_val[ch]  = SAT ? max_of(ch) : 0;
        end else begin
          m_val[ch] = m_val[ch] + 1;
        end
      end else if (d[ch] && !i[ch]) begin
        if (m_val[ch] == 0) begin
          m_wrap[ch] = 1'b1;
          m_val[ch]  = SAT ? 0 : max_of(ch);
        end else begin
          m_val[ch] = m_val[ch] - 1;
        end
      end
    end
    if (n || m_since == SCR - 1) begin
      m_disp  = (m_disp + 1) % NCH;
      m_since = 0;
    end else begin
      m_since = m_since + 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/count"},       count,              exp_count());
    chk({tag, "/wrap_flag"},   {28'd0, wrap_flag}, {28'd0, exp_wrap()});
    chk({tag, "/disp_ch"},     {30'd0, disp_ch},   32'(m_disp));
    chk({tag, "/encoded"},     {24'd0, encoded},   {24'd0, m_enc});
    chk({tag, "/digit_point"}, {30'd0, digit_point}, {30'd0, m_dp});
  endtask

  task automatic cyc(input string tag, input logic [3:0] i, input logic [3:0] d,
                     input logic [3:0] c, input logic n);
    inc = i; dec = d; clr = c; next_ch = n;
    @(posedge clk);
    model_edge(i, d, c, n);
    #1;
    inc = 4'd0; dec = 4'd0; clr = 4'd0; next_ch = 1'b0;
    check_all(tag);
  endtask

  // reset mid-cycle, check immediate clear, hold over edges with pulses on the release edge
  task automatic do_reset(input logic [3:0] release_pulse);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("reset_async");
    @(posedge clk);
    inc = release_pulse; dec = release_pulse; next_ch = release_pulse[0];
    @(posedge clk);
    #1;
    reset = 1'b0;
    inc = 4'd0; dec = 4'd0; next_ch = 1'b0;
    check_all("reset_release");
  endtask

  initial begin
    reset = 1'b1; inc = 4'd0; dec = 4'd0; clr = 4'd0; next_ch = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("reset_state");

    // hex ch0 up to max then over the top
    repeat (255) cyc("hex_up", 4'b0001, 4'd0, 4'd0, 1'b0);
    chk("hex_at_max", {24'd0, count[7:0]}, 32'h0000_00FF);
    cyc("hex_over", 4'b0001, 4'd0, 4'd0, 1'b0);
    chk("hex_over_val", {24'd0, count[7:0]}, {24'd0, HEX_OVER_EXP});
    chk("hex_over_flag", {31'd0, wrap_flag[0]}, 32'd1);

    // BCD ch2 ripple and underflow
    repeat (10) cyc("bcd_up", 4'b0100, 4'd0, 4'd0, 1'b0);
    chk("bcd_10", {24'd0, count[23:16]}, 32'h0000_0010);
    cyc("bcd_dn", 4'd0, 4'b0100, 4'd0, 1'b0);
    chk("bcd_09", {24'd0, count[23:16]}, 32'h0000_0009);
    repeat (9) cyc("bcd_dn", 4'd0, 4'b0100, 4'd0, 1'b0);
    cyc("bcd_under", 4'd0, 4'b0100, 4'd0, 1'b0);
    chk("bcd_under_val", {24'd0, count[23:16]}, {24'd0, DEC_UNDER_EXP});
    chk("bcd_under_flag", {31'd0, wrap_flag[2]}, 32'd1);

    // ch1 priority: clr beats inc and clears the flag, inc+dec cancel
    cyc("ch1_dn0", 4'd0, 4'b0010, 4'd0, 1'b0);
    cyc("ch1_incclr", 4'b0010, 4'd0, 4'b0010, 1'b0);
    chk("ch1_clr_flag", {31'd0, wrap_flag[1]}, 32'd0);
    repeat (5) cyc("ch1_up", 4'b0010, 4'd0, 4'd0, 1'b0);
    cyc("ch1_incdec", 4'b0010, 4'b0010, 4'd0, 1'b0);
    chk("ch1_hold5", {24'd0, count[15:8]}, 32'd5);
    cyc("ch1_incclr5", 4'b0010, 4'd0, 4'b0010, 1'b0);
    chk("ch1_zero", {24'd0, count[15:8]}, 32'd0);
    chk("ch1_zero_flag", {31'd0, wrap_flag[1]}, 32'd0);

    // all channels together
    cyc("all_inc", 4'b1111, 4'd0, 4'd0, 1'b0);
    cyc("all_dec", 4'd0, 4'b1111, 4'd0, 1'b0);

    // auto-scroll timing and manual advance mid-dwell
    do_reset(4'd0);
    repeat (7) cyc("scroll", 4'd0, 4'd0, 4'd0, 1'b0);
    chk("scroll_hold7", {30'd0, disp_ch}, 32'd0);
    cyc("scroll", 4'd0, 4'd0, 4'd0, 1'b0);
    chk("scroll_adv8", {30'd0, disp_ch}, 32'd1);
    repeat (24) cyc("scroll", 4'd0, 4'd0, 4'd0, 1'b0);
    chk("scroll_wrap", {30'd0, disp_ch}, 32'd0);
    repeat (5) cyc("scroll", 4'd0, 4'd0, 4'd0, 1'b0);
    cyc("manual_adv", 4'd0, 4'd0, 4'd0, 1'b1);
    chk("manual_adv_ch", {30'd0, disp_ch}, 32'd1);
    repeat (7) cyc("scroll", 4'd0, 4'd0, 4'd0, 1'b0);
    chk("dwell_restart_hold", {30'd0, disp_ch}, 32'd1);
    cyc("scroll", 4'd0, 4'd0, 4'd0, 1'b0);
    chk("dwell_restart_adv", {30'd0, disp_ch}, 32'd2);

    // display latency and decimal point tracking on ch0
    do_reset(4'd0);
    cyc("lat_pulse", 4'b0001, 4'd0, 4'd0, 1'b0);
    chk("lat_count_n1", {24'd0, count[7:0]}, 32'd1);
    chk("lat_enc_n1", {24'd0, encoded}, 32'd0);
    cyc("lat_idle", 4'd0, 4'd0, 4'd0, 1'b0);
    chk("lat_enc_n2", {24'd0, encoded}, 32'd1);
    cyc("dp_dn", 4'd0, 4'b0001, 4'd0, 1'b0);
    cyc("dp_wrap", 4'd0, 4'b0001, 4'd0, 1'b0);
    cyc("dp_idle", 4'd0, 4'd0, 4'd0, 1'b0);
    chk("dp_flag", {31'd0, digit_point[0]}, 32'd1);

    // randomized pulses
    for (int k = 0; k < 400; k++) begin
      cyc("rand", 4'($urandom & $urandom), 4'($urandom & $urandom),
          4'($urandom & $urandom & $urandom), ($urandom_range(0, 9) == 0));
    end

    // reset mid-count with ch0=3, disp_ch=2
    do_reset(4'd0);
    cyc("pre_rst", 4'b0001, 4'd0, 4'd0, 1'b1);
    cyc("pre_rst", 4'b0001, 4'd0, 4'd0, 1'b1);
    cyc("pre_rst", 4'b0001, 4'd0, 4'd0, 1'b0);
    chk("pre_rst_ch0", {24'd0, count[7:0]}, 32'd3);
    chk("pre_rst_disp", {30'd0, disp_ch}, 32'd2);
    do_reset(4'b1111);
    cyc("post_rst", 4'd0, 4'd0, 4'd0, 1'b0);
    cyc("post_rst_inc", 4'b0001, 4'd0, 4'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
